// File: rtl/rst_dbg_seq.sv
// rst_dbg_seq -- programmable reset sequencer with selectable debug capture.
//
// After i_rst_n or an i_ext_hold request the core is held in reset for
// RST_CYCLES cycles. After release a registered debug bus is driven from the
// selected channel in live, sampled or sticky-OR mode. The bus freezes when
// the CPU reports done.
//
// Build option: define RST_DBG_STICKY_EN to compile in the sticky-OR capture
// mode (mode 2). Without it, mode 2 behaves exactly like sampled mode (1) and
// the accumulator/select-change tracking is not built.
module rst_dbg_seq #(
    parameter int RST_CYCLES = 31,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 8,
    parameter int OUT_W      = 8,
    localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_ext_hold,
    input  logic                   i_freeze,
    input  logic [SEL_W-1:0]       i_sel,
    input  logic [1:0]             i_mode,
    input  logic [NUM_CH*CH_W-1:0] i_ch_data,
    input  logic [NUM_CH-1:0]      i_ch_valid,
    output logic                   o_core_rst,
    output logic                   o_rst_done,
    output logic [OUT_W-1:0]       o_debug_data,
    output logic                   o_debug_valid
);

    localparam int               CNT_W    = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             core_rst_q;
    logic             rst_done_q;
    logic [OUT_W-1:0] dbg_data_q;
    logic             dbg_valid_q;

    logic [CH_W-1:0]  ch_raw_s;
    logic             ch_vld_s;
    logic [OUT_W-1:0] sel_data_s;
    logic [OUT_W-1:0] dbg_data_d;
    logic             dbg_valid_d;

    // Channel multiplexer: a select beyond the last channel reads as no data, no strobe.
    always_comb begin
        ch_raw_s = {CH_W{1'b0}};
        ch_vld_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if ({1'b0, i_sel} == (SEL_W + 1)'(k)) begin
                ch_raw_s = i_ch_data[k*CH_W +: CH_W];
                ch_vld_s = i_ch_valid[k];
            end else begin
                ch_raw_s = ch_raw_s;
                ch_vld_s = ch_vld_s;
            end
        end
    end

    // Resize the selected channel to the bus width, keeping the LSBs.
    generate
        if (OUT_W > CH_W) begin : g_zext
            assign sel_data_s = {{(OUT_W - CH_W){1'b0}}, ch_raw_s};
        end else begin : g_trunc
            assign sel_data_s = ch_raw_s[OUT_W-1:0];
        end
    endgenerate

`ifdef RST_DBG_STICKY_EN
    logic [SEL_W-1:0] prev_sel_q;
    logic             sel_chg_s;

    // Remember last cycle's select so the sticky accumulator restarts on a change.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prev_sel_q <= {SEL_W{1'b0}};
        end else begin
            prev_sel_q <= i_sel;
        end
    end

    assign sel_chg_s = (prev_sel_q != i_sel);
`endif

    // Next debug bus value while running, by capture mode.
    always_comb begin
        dbg_data_d  = dbg_data_q;
        dbg_valid_d = 1'b0;
        case (i_mode)
            2'd0, 2'd3: begin
                dbg_data_d  = sel_data_s;
                dbg_valid_d = 1'b1;
            end
            2'd1: begin
                if (ch_vld_s) begin
                    dbg_data_d = sel_data_s;
                end else begin
                    dbg_data_d = dbg_data_q;
                end
                dbg_valid_d = ch_vld_s;
            end
            2'd2: begin
`ifdef RST_DBG_STICKY_EN
                // A new select starts a fresh accumulation instead of OR-ing.
                if (sel_chg_s) begin
                    dbg_data_d = ch_vld_s ? sel_data_s : {OUT_W{1'b0}};
                end else if (ch_vld_s) begin
                    dbg_data_d = dbg_data_q | sel_data_s;
                end else begin
                    dbg_data_d = dbg_data_q;
                end
                dbg_valid_d = ch_vld_s;
`else
                if (ch_vld_s) begin
                    dbg_data_d = sel_data_s;
                end else begin
                    dbg_data_d = dbg_data_q;
                end
                dbg_valid_d = ch_vld_s;
`endif
            end
            default: begin
                dbg_data_d  = dbg_data_q;
                dbg_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered reset, status and debug outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= {CNT_W{1'b0}};
            core_rst_q  <= 1'b1;
            rst_done_q  <= 1'b0;
            dbg_data_q  <= {OUT_W{1'b0}};
            dbg_valid_q <= 1'b0;
        end else if (i_ext_hold) begin
            state_q     <= ST_HOLD;
            cnt_q       <= {CNT_W{1'b0}};
            core_rst_q  <= 1'b1;
            rst_done_q  <= 1'b0;
            dbg_data_q  <= {OUT_W{1'b0}};
            dbg_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    dbg_data_q  <= {OUT_W{1'b0}};
                    dbg_valid_q <= 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        state_q    <= ST_RUN;
                        cnt_q      <= {CNT_W{1'b0}};
                        core_rst_q <= 1'b0;
                        rst_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (i_freeze) begin
                        state_q     <= ST_FROZEN;
                        dbg_valid_q <= 1'b0;
                    end else begin
                        dbg_data_q  <= dbg_data_d;
                        dbg_valid_q <= dbg_valid_d;
                    end
                end
                ST_FROZEN: begin
                    dbg_valid_q <= 1'b0;
                end
                default: begin
                    state_q     <= ST_HOLD;
                    cnt_q       <= {CNT_W{1'b0}};
                    core_rst_q  <= 1'b1;
                    rst_done_q  <= 1'b0;
                    dbg_data_q  <= {OUT_W{1'b0}};
                    dbg_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_core_rst    = core_rst_q;
    assign o_rst_done    = rst_done_q;
    assign o_debug_data  = dbg_data_q;
    assign o_debug_valid = dbg_valid_q;

endmodule
